// File: rtl/ex_mem_latch.sv
// ---------------------------------------------------------------------------
// ex_mem_latch
//   Pipeline register between the execute and memory stages of the 5-stage
//   WISC-SP13 pipeline. Latches execute results and control every cycle,
//   with stall (hold) and flush (bubble) control, a halt state machine that
//   lets HALT reach the memory stage exactly once, a forwarding tap for the
//   execute stage and a sticky illegal-control error flag.
//
// Ports
//   clk                       clock, rising edge
//   rst                       asynchronous reset, active low
//   Stall / Flush             hold all state / load a bubble (Flush wins)
//   *_In_FromX, *_FromX       execute-stage instruction fields
//   *_ToM                     latched fields to the memory stage
//   Fwd_En / Fwd_WR / Fwd_Data forwarding tap, driven from latched state only
//   Halted                    pipeline has halted (leaves only via reset)
//   err                       sticky: a valid load+store instruction was seen
//   Dbg_State                 halt FSM state (0 RUN, 1 HALT1, 2 HALTED)
//
// Handshake: there is no valid/ready pair; Valid_In_FromX qualifies the
// execute slot on every unstalled edge and Valid_ToM qualifies the memory
// slot one cycle later. Stall is the only back-pressure.
// ---------------------------------------------------------------------------
module ex_mem_latch #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Stall,
  input  logic          Flush,
  input  logic          Valid_In_FromX,
  input  logic          RegWriteDataSel_In_FromX,
  input  logic          MemReadEn_In_FromX,
  input  logic          MemWriteEn_In_FromX,
  input  logic          WriteToReg_FromX,
  input  logic          Halt_In_FromX,
  input  logic [DW-1:0] ALUResult_In_FromX,
  input  logic [DW-1:0] RD2_In_FromX,
  input  logic [RW-1:0] WR_In_FromX,
  output logic          Valid_ToM,
  output logic          RegWriteDataSel_ToM,
  output logic          MemReadEn_ToM,
  output logic          MemWriteEn_ToM,
  output logic          WriteToReg_ToM,
  output logic          Halt_ToM,
  output logic [DW-1:0] ALUResult_ToM,
  output logic [DW-1:0] RD2_ToM,
  output logic [RW-1:0] WR_ToM,
  output logic          Fwd_En,
  output logic [RW-1:0] Fwd_WR,
  output logic [DW-1:0] Fwd_Data,
  output logic          Halted,
  output logic          err,
  output logic [1:0]    Dbg_State
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALT1  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e        state_q;
  logic          valid_q;
  // Control bundle: {RegWriteDataSel, MemReadEn, MemWriteEn, WriteToReg, Halt}
  logic [4:0]    ctrl_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] rd2_q;
  logic [RW-1:0] wr_q;
  logic          err_q;

  logic [4:0]    ctrl_in;
  assign ctrl_in = {RegWriteDataSel_In_FromX, MemReadEn_In_FromX,
                    MemWriteEn_In_FromX, WriteToReg_FromX, Halt_In_FromX};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      rd2_q   <= '0;
      wr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        // Everything after the halt is squashed; inputs, Stall and Flush
        // are all ignored until reset.
        S_HALTED: begin
          valid_q <= 1'b0;
          ctrl_q  <= '0;
        end
        // The halt instruction is presented now. Flush cannot remove it;
        // a stall keeps it (and Halt_ToM) in place.
        S_HALT1: begin
          if (!Stall) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            state_q <= S_HALTED;
          end
        end
        default: begin
          if (Flush) begin
            // Data fields deliberately hold; only the qualifiers drop.
            valid_q <= 1'b0;
            ctrl_q  <= '0;
          end else if (!Stall) begin
            valid_q <= Valid_In_FromX;
            ctrl_q  <= Valid_In_FromX ? ctrl_in : 5'b0;
            alu_q   <= ALUResult_In_FromX;
            rd2_q   <= RD2_In_FromX;
            wr_q    <= WR_In_FromX;
            if (Valid_In_FromX && Halt_In_FromX)
              state_q <= S_HALT1;
            if (Valid_In_FromX && MemReadEn_In_FromX && MemWriteEn_In_FromX)
              err_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign Valid_ToM           = valid_q;
  assign RegWriteDataSel_ToM = ctrl_q[4];
  assign MemReadEn_ToM       = ctrl_q[3];
  assign MemWriteEn_ToM      = ctrl_q[2];
  assign WriteToReg_ToM      = ctrl_q[1];
  assign Halt_ToM            = ctrl_q[0];
  assign ALUResult_ToM       = alu_q;
  assign RD2_ToM             = rd2_q;
  assign WR_ToM              = wr_q;

  // Load data is not available until the memory stage reads it, so a load
  // in this slot must not be forwarded.
  assign Fwd_En   = valid_q & ctrl_q[1] & ~ctrl_q[3];
  assign Fwd_WR   = wr_q;
  assign Fwd_Data = alu_q;

  assign Halted    = (state_q == S_HALTED);
  assign err       = err_q;
  assign Dbg_State = state_q;

endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
- Pipeline register between the execute stage and the memory stage of the 5-stage WISC-SP13 pipeline.
- Captures execute results and control each cycle, with stall (hold) and flush (bubble) control.
- Runs a halt state machine so the halt instruction reaches the memory stage exactly once and everything after it is squashed.
- Provides a forwarding tap for the execute stage and a sticky illegal-control error flag.

Parameters:
- DW, 16, datapath width (ALU result, store data).
- RW, 3, register-specifier width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- Stall  in  1  hold all latched state.
- Flush  in  1  load a bubble.
- Valid_In_FromX  in  1  execute slot holds a real instruction.
- RegWriteDataSel_In_FromX  in  1  writeback mux select.
- MemReadEn_In_FromX  in  1  load.
- MemWriteEn_In_FromX  in  1  store.
- WriteToReg_FromX  in  1  register write enable.
- Halt_In_FromX  in  1  instruction is HALT.
- ALUResult_In_FromX  in  DW  ALU result / memory address.
- RD2_In_FromX  in  DW  store data.
- WR_In_FromX  in  RW  destination register.
- Valid_ToM  out  1  latched valid.
- RegWriteDataSel_ToM, MemReadEn_ToM, MemWriteEn_ToM, WriteToReg_ToM, Halt_ToM  out  1 each  latched control.
- ALUResult_ToM  out  DW  latched ALU result.
- RD2_ToM  out  DW  latched store data.
- WR_ToM  out  RW  latched destination register.
- Fwd_En  out  1  forwarding tap valid.
- Fwd_WR  out  RW  forwarding destination register.
- Fwd_Data  out  DW  forwarding value.
- Halted  out  1  pipeline has halted.
- err  out  1  sticky illegal-control error.

Behaviour:
- Reset (rst=0, asynchronous):
  - All latched outputs = 0.
  - Halted = 0, err = 0, FSM = RUN.
  - Takes effect immediately, mid-cycle included; the first edge after release behaves as normal RUN operation.
- Per-edge priority, highest first: HALTED squash > Flush > Stall > load.
- Load:
  - Valid_ToM <= Valid_In_FromX.
  - If Valid_In_FromX=0: MemReadEn, MemWriteEn, WriteToReg, Halt, RegWriteDataSel latch as 0, regardless of inputs.
  - Data fields (ALUResult, RD2, WR) always latch input values.
- Flush: Valid and all control outputs <= 0; data fields hold.
- Stall: every register holds, including FSM and err.
- Flush and Stall both asserted: Flush wins.
- Latency: exactly 1 cycle from input to _ToM output. No combinational input-to-output paths.
- Halt FSM:
  - RUN: a load with Valid_In_FromX=1 and Halt_In_FromX=1 latches Halt_ToM=1 and moves to HALT1.
  - HALT1: Halt_ToM is high for this cycle. On the next non-stalled edge, load a bubble and move to HALTED. A stall holds HALT1 and keeps Halt_ToM high. Flush in HALT1 is ignored: the halt instruction is never flushed.
  - HALTED: every edge loads a bubble (all control 0, Valid 0), ignoring inputs, Stall and Flush. Halted=1. Exit only by reset.
  - Halt_ToM is therefore high for exactly one unstalled cycle, so the memory dump fires once.
- Forwarding tap (combinational from latched state only):
  - Fwd_En = Valid_ToM & WriteToReg_ToM & ~MemReadEn_ToM. Loads are not forwardable from this stage.
  - Fwd_WR = WR_ToM.
  - Fwd_Data = ALUResult_ToM.
- err:
  - Set when a valid instruction is loaded with MemReadEn_In_FromX=1 and MemWriteEn_In_FromX=1.
  - The instruction is still latched as given.
  - Sticky until reset.
  - Not set by bubbles or by squashed inputs in HALTED.
- Arithmetic: none; all fields pass through at width, with no truncation or extension.

Test Plan:
- Reset, then load valid ADD (ALUResult=16'h1234, WR=3, WriteToReg=1) -> next cycle Valid_ToM=1, ALUResult_ToM=16'h1234, Fwd_En=1, Fwd_WR=3, Fwd_Data=16'h1234.
- Valid load (MemReadEn=1, WR=5) -> MemReadEn_ToM=1, Fwd_En=0. Then Valid_In=0 with MemWriteEn_In=1 -> MemWriteEn_ToM=0, Valid_ToM=0.
- Latch store (RD2=16'hBEEF); assert Stall 3 cycles while inputs change -> RD2_ToM stays 16'hBEEF. Assert Stall+Flush together -> Valid_ToM=0, all controls 0.
- Valid HALT loaded, Stall 2 cycles, then release -> Halt_ToM high for 3 cycles (2 stalled + 1 unstalled), then 0. Halted=1 afterwards. Subsequent valid inputs with Flush/Stall toggling -> Valid_ToM stays 0.
- Valid input with MemReadEn=MemWriteEn=1 -> err=1 next cycle and stays 1 through further loads. rst=0 pulse mid-cycle -> err, Halted and all outputs 0 immediately, before the next clock edge.
